hamming_serial_rx: RTL and testbench



---
 rtl/hamming_pkg.sv | 31 +++
 rtl/hamming_rx_fifo.sv | 54 +++++
 rtl/hamming_serial_rx.sv | 96 +++++++++
 tb/tb_hamming_serial_rx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared constants, FSM encoding and the Hamming(7,4) syndrome decoder
// used by the serial receive front end.
package hamming_pkg;

  localparam int CODE_W = 7;
  localparam int DATA_W = 4;
  localparam int SYN_W  = 3;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    STOP
  } state_t;

  // Returns {err, data[4:1]}; parity p folds into every syndrome bit so odd
  // parity codewords decode to a zero syndrome when clean.
  function automatic logic [DATA_W:0] hamming_decode(input logic [CODE_W:1] c,
                                                     input logic p);
    logic [SYN_W:1]  s;
    logic [CODE_W:1] cc;
    s[1] = c[1] ^ c[3] ^ c[5] ^ c[7] ^ p;
    s[2] = c[2] ^ c[3] ^ c[6] ^ c[7] ^ p;
    s[3] = c[4] ^ c[5] ^ c[6] ^ c[7] ^ p;
    cc   = c;
    for (int i = 1; i <= CODE_W; i++) begin
      if (int'(s) == i) cc[i] = ~cc[i];
    end
    return {(s != '0), cc[7], cc[6], cc[5], cc[3]};
  endfunction

endpackage

// File: rtl/hamming_rx_fifo.sv
// Synchronous FIFO buffering decoded {err, nibble} entries. Head data reads
// as zero while empty so the block's outputs start at zero out of reset.
module hamming_rx_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  // A pop frees the slot in the same cycle, so a push into a full FIFO is taken.
  assign w_wr      = i_push && (!o_full || i_pop);
  assign w_rd      = i_pop && !o_empty;
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/hamming_serial_rx.sv
// Serial Hamming(7,4) receiver: deframes start/7 bits/stop, corrects single
// bit errors and queues nibbles behind a valid/ready output.
module hamming_serial_rx
  import hamming_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       parity_type,
  input  logic       ser_valid,
  input  logic       ser_bit,
  output logic [4:1] out_data,
  output logic       out_err,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_err,
  output logic       overflow
);

  state_t          r_state;
  logic            r_par;
  logic [2:0]      r_cnt;
  logic [CODE_W:1] r_code;
  logic            r_frame_err;
  logic            r_overflow;

  logic            w_stop_strobe;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [DATA_W:0] w_dec;
  logic [DATA_W:0] w_head;

  assign w_stop_strobe = (r_state == STOP) && ser_valid;
  assign w_push        = w_stop_strobe && ser_bit;
  assign w_pop         = out_valid && out_ready;
  assign w_dec         = hamming_decode(r_code, r_par);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_par       <= 1'b0;
      r_cnt       <= '0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_frame_err <= w_stop_strobe && !ser_bit;
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      if (ser_valid) begin
        case (r_state)
          IDLE: begin
            if (!ser_bit) begin
              r_par   <= parity_type;
              r_cnt   <= '0;
              r_state <= DATA;
            end
          end
          DATA: begin
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == 3'd6) r_state <= STOP;
          end
          STOP:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // c1 arrives first and ends up in r_code[1] after seven right shifts.
  always_ff @(posedge clk) begin
    if (ser_valid && (r_state == DATA)) r_code <= {ser_bit, r_code[CODE_W:2]};
  end

  hamming_rx_fifo #(
    .WIDTH(DATA_W + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_wr_data(w_dec),
    .o_rd_data(w_head),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  assign out_valid = !w_empty;
  assign out_data  = w_head[DATA_W-1:0];
  assign out_err   = w_head[DATA_W];
  assign frame_err = r_frame_err;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_hamming_serial_rx.sv
// Bench for hamming_serial_rx: directed and random frames checked against
// an index-XOR Hamming model and a queue model of the output buffer.
module tb_hamming_serial_rx;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       parity_type;
  logic       ser_valid;
  logic       ser_bit;
  logic       out_ready;
  logic [4:1] out_data;
  logic       out_err;
  logic       out_valid;
  logic       frame_err;
  logic       overflow;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [4:0] exp_q[$];
  logic       ovf_exp = 1'b0;
  int         gap_max = 0;

  always #5 clk = ~clk;

  hamming_serial_rx #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .parity_type(parity_type),
    .ser_valid  (ser_valid),
    .ser_bit    (ser_bit),
    .out_data   (out_data),
    .out_err    (out_err),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  // Syndrome = XOR of the indices of all set bits, with odd parity inverting it.
  function automatic logic [4:0] ref_decode(input logic [7:1] c, input logic p);
    int pos;
    pos = p ? 7 : 0;
    for (int i = 1; i <= 7; i++) if (c[i]) pos = pos ^ i;
    if (pos != 0) c[pos] = ~c[pos];
    return {(pos != 0), c[7], c[6], c[5], c[3]};
  endfunction

  function automatic logic [7:1] ref_encode(input logic [4:1] d, input logic p);
    logic [7:1] c;
    int s;
    c = '0;
    c[3] = d[1]; c[5] = d[2]; c[6] = d[3]; c[7] = d[4];
    s = p ? 7 : 0;
    for (int i = 1; i <= 7; i++) if (c[i]) s = s ^ i;
    c[1] = s[0]; c[2] = s[1]; c[4] = s[2];
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_gap();
    int g;
    g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
    repeat (g) begin
      ser_valid = 1'b0;
      ser_bit   = 1'($urandom);
      @(posedge clk); #1;
    end
    ser_bit = 1'b1;
  endtask

  task automatic send_bit(input logic b);
    idle_gap();
    ser_valid = 1'b1;
    ser_bit   = b;
    @(posedge clk); #1;
    ser_valid = 1'b0;
    ser_bit   = 1'b1;
  endtask

  task automatic send_frame(input logic [7:1] c, input logic p, input logic stop,
                            input logic pop_at_stop);
    logic [4:0] dec;
    logic       nonempty;
    dec = ref_decode(c, p);
    parity_type = p;
    send_bit(1'b0);
    for (int i = 1; i <= 7; i++) begin
      parity_type = 1'($urandom);
      send_bit(c[i]);
    end
    parity_type = 1'($urandom);
    idle_gap();
    ser_valid = 1'b1;
    ser_bit   = stop;
    nonempty  = (exp_q.size() != 0);
    if (pop_at_stop) begin
      out_ready = 1'b1;
      chk("valid_at_stop", out_valid, nonempty);
      if (nonempty) chk("head_at_stop", {out_err, out_data}, exp_q[0]);
    end
    @(posedge clk); #1;
    ser_valid = 1'b0;
    ser_bit   = 1'b1;
    out_ready = 1'b0;
    if (pop_at_stop && nonempty) void'(exp_q.pop_front());
    if (stop) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(dec);
      else ovf_exp = 1'b1;
    end
    chk("frame_err", frame_err, !stop);
    chk("overflow", overflow, ovf_exp);
    chk("valid_after_frame", out_valid, (exp_q.size() != 0));
    if (!stop) begin
      @(posedge clk); #1;
      chk("frame_err_clear", frame_err, 1'b0);
    end
  endtask

  task automatic drain();
    logic r;
    for (int k = 0; k < 64 && exp_q.size() != 0; k++) begin
      r = ($urandom % 3) != 0;
      out_ready = r;
      chk("drain_valid", out_valid, 1'b1);
      chk("drain_head", {out_err, out_data}, exp_q[0]);
      @(posedge clk); #1;
      if (r) void'(exp_q.pop_front());
    end
    out_ready = 1'b0;
    chk("drain_bound", exp_q.size(), 0);
    chk("valid_after_drain", out_valid, 1'b0);
  endtask

  initial begin
    logic [7:1] c;
    logic [4:1] d;
    logic       p;
    int         k;

    rst_n = 1'b0; ser_valid = 1'b0; ser_bit = 1'b1; parity_type = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_data", out_data, 4'h0);
    chk("rst_out_err", out_err, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Clean even-parity frame for 1011, back-to-back strobes.
    send_frame(7'b1010101, 1'b0, 1'b1, 1'b0);
    chk("clean_data", out_data, 4'b1011);
    chk("clean_err", out_err, 1'b0);
    drain();

    // c5 flipped.
    send_frame(7'b1000101, 1'b0, 1'b1, 1'b0);
    chk("c5flip_data", out_data, 4'b1011);
    chk("c5flip_err", out_err, 1'b1);
    drain();

    // c1 wrong: corrected parity bit, data untouched.
    send_frame(7'b1010100, 1'b0, 1'b1, 1'b0);
    chk("c1flip_data", out_data, 4'b1011);
    chk("c1flip_err", out_err, 1'b1);
    drain();

    // Odd parity, then the same codeword decoded as even.
    c = ref_encode(4'b0110, 1'b1);
    send_frame(c, 1'b1, 1'b1, 1'b0);
    chk("odd_data", out_data, 4'b0110);
    chk("odd_err", out_err, 1'b0);
    drain();
    send_frame(c, 1'b0, 1'b1, 1'b0);
    chk("odd_as_even_err", out_err, 1'b1);
    drain();

    // Bad stop bit followed by a good frame.
    gap_max = 2;
    send_frame(ref_encode(4'b1100, 1'b0), 1'b0, 1'b0, 1'b0);
    send_frame(ref_encode(4'b0011, 1'b0), 1'b0, 1'b1, 1'b0);
    drain();

    // Overflow with out_ready held low, then push+pop while full.
    gap_max = 1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      d = 4'($urandom);
      p = 1'($urandom);
      send_frame(ref_encode(d, p), p, 1'b1, 1'b0);
    end
    chk("overflow_set", overflow, 1'b1);
    d = 4'($urandom);
    send_frame(ref_encode(d, 1'b0), 1'b0, 1'b1, 1'b1);
    drain();

    // Push while out_ready high on an empty FIFO: no bypass.
    send_frame(ref_encode(4'b1001, 1'b1), 1'b1, 1'b1, 1'b1);
    drain();

    // Reset in the middle of a frame with a stale entry queued.
    send_frame(ref_encode(4'b0101, 1'b0), 1'b0, 1'b1, 1'b0);
    c = ref_encode(4'b1110, 1'b0);
    send_bit(1'b0);
    for (int i = 1; i <= 4; i++) send_bit(c[i]);
    rst_n = 1'b0;
    #2;
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_overflow", overflow, 1'b0);
    chk("midrst_data", out_data, 4'h0);
    exp_q.delete();
    ovf_exp = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_valid", out_valid, 1'b0);
    send_frame(ref_encode(4'b1110, 1'b1), 1'b1, 1'b1, 1'b0);
    chk("postrst_data", out_data, 4'b1110);
    drain();

    // Random frames with occasional single-bit errors and bad stops.
    gap_max = 2;
    for (int i = 0; i < 24; i++) begin
      d = 4'($urandom);
      p = 1'($urandom);
      c = ref_encode(d, p);
      if ($urandom % 3 == 0) begin
        k = $urandom_range(1, 7);
        c[k] = ~c[k];
      end
      send_frame(c, p, ($urandom % 8) != 0, ($urandom % 4) == 0);
      if (exp_q.size() == DEPTH || ($urandom % 3) == 0) drain();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
